// File: rtl/parity_arb_ctrl.sv
// Round-robin arbiter in front of a bit-serial parity engine: a granted word is
// folded one bit per clock into a 1-bit XOR accumulator and returned with its requester id.
module parity_arb_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              res_valid,
  output logic              res_parity,
  output logic              res_id,
  input  logic              res_ready,
  output logic              busy
);

  localparam int unsigned     CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic              grant;
  logic              accept;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = ~rst & (state_q == StIdle) & req0_valid & ~grant;
  assign req1_ready = ~rst & (state_q == StIdle) & req1_valid & grant;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d    = grant ? req1_data : req0_data;
          acc_d   = ODD;
          cnt_d   = '0;
          id_d    = grant;
          last_d  = grant;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = acc_q ^ sr_q[0];
        sr_d  = sr_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign res_valid  = (state_q == StDone);
  assign res_parity = (state_q == StDone) & acc_q;
  assign res_id     = id_q;
  assign busy       = (state_q != StIdle);

endmodule
